// File: rtl/vram_capture_writer_pkg.sv
// Shared constants, FIFO entry layout and FSM encoding for the
// capture-side VRAM writer.
package vram_capture_writer_pkg;

    localparam int X_BITS  = 10;
    localparam int Y_BITS  = 9;
    localparam int ADDR_W  = X_BITS + Y_BITS;
    localparam int PIX_W   = 30;
    localparam int PAD_W   = 6;
    localparam int DATA_W  = PIX_W + PAD_W;
    localparam int ENTRY_W = ADDR_W + PIX_W;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        CAPTURE  = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  pix;
    } entry_t;

    // Same {y, x} packing the display read side uses.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/vram_capture_writer_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module vram_capture_writer_sync_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/vram_capture_writer.sv
// Tags a raster pixel stream with frame coordinates, buffers it and
// writes it into ZBT VRAM during arbiter-granted write slots.
module vram_capture_writer
    import vram_capture_writer_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eol,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              frame_enable,
    input  logic              wr_slot,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_write_addr,
    output logic [DATA_W-1:0] vram_write_data,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
);

    localparam logic [X_BITS:0]   H_LIM  = H_ACTIVE[X_BITS:0];
    localparam logic [Y_BITS:0]   V_LIM  = V_ACTIVE[Y_BITS:0];
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_ACTIVE - 1);

    state_e            r_state;
    logic [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0] r_y;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              r_ovf;

    logic              w_sof;
    logic              w_start;
    logic              w_take;
    logic              w_push;
    logic              w_pop;
    logic              w_eof;
    logic              w_full;
    logic              w_empty;
    logic [X_BITS-1:0] w_px;
    logic [Y_BITS-1:0] w_py;
    entry_t            w_entry;
    entry_t            w_head;

    always_comb begin
        w_sof   = pix_valid & pix_sof;
        w_start = w_sof & frame_enable & (r_state != DRAIN);
        w_take  = w_start |
                  (pix_valid & ~pix_sof & (r_state == CAPTURE));
        w_px    = w_start ? '0 : r_x;
        w_py    = w_start ? '0 : r_y;
        w_push  = w_take &
                  ({1'b0, w_px} < H_LIM) &
                  ({1'b0, w_py} < V_LIM);
        w_eof   = w_take & pix_eol & (w_py == Y_LAST);
        w_pop   = wr_slot & ~w_empty;
        w_entry = '{addr: pack_addr(w_px, w_py), pix: pix_data};
    end

    vram_capture_writer_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_SOF;
            r_x     <= '0;
            r_y     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_we   <= w_pop;
            r_done <= 1'b0;
            if (w_pop) begin
                r_addr <= w_head.addr;
                r_data <= {PAD_W'(0), w_head.pix};
            end
            if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
            // Coordinates saturate rather than wrap on runaway lines.
            if (w_take) begin
                if (pix_eol) begin
                    r_x <= '0;
                    r_y <= (w_py == '1) ? w_py : w_py + 1'b1;
                end else begin
                    r_x <= (w_px == '1) ? w_px : w_px + 1'b1;
                    r_y <= w_py;
                end
            end
            unique case (r_state)
                WAIT_SOF: begin
                    if (w_eof)        r_state <= DRAIN;
                    else if (w_start) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    if (w_eof)
                        r_state <= DRAIN;
                    else if (w_sof & ~frame_enable)
                        r_state <= WAIT_SOF;
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= WAIT_SOF;
                    end
                end
                default: r_state <= WAIT_SOF;
            endcase
        end
    end

    assign vram_we         = r_we;
    assign vram_write_addr = r_addr;
    assign vram_write_data = r_data;
    assign frame_done      = r_done;
    assign overflow        = r_ovf;
    assign busy            = (r_state != WAIT_SOF) | ~w_empty;

endmodule

// File: tb/tb_vram_capture_writer.sv
// Directed bench for vram_capture_writer; frame height is reduced to
// keep runtime short while keeping the full 640-pixel line width.
module tb_vram_capture_writer;

    localparam int TH   = 640;
    localparam int TV   = 4;
    localparam int FULL = TH * TV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic [29:0] pix_data = '0;
    logic        frame_enable = 1'b1;
    logic        wr_slot = 1'b0;
    logic        vram_we;
    logic [18:0] vram_write_addr;
    logic [35:0] vram_write_data;
    logic        frame_done;
    logic        overflow;
    logic        busy;

    int passed = 0;
    int total  = 0;

    int          wr_cnt = 0;
    int          fd_cnt = 0;
    int          wr_after_fd = 0;
    int          bad_data = 0;
    int          max_x = 0;
    bit          seen_27f = 0;
    logic [18:0] first_addr = '0;
    logic [18:0] last_addr = '0;
    logic [18:0] alog[$];

    vram_capture_writer #(
        .H_ACTIVE   (TH),
        .V_ACTIVE   (TV),
        .FIFO_DEPTH (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pix_valid       (pix_valid),
        .pix_sof         (pix_sof),
        .pix_eol         (pix_eol),
        .pix_data        (pix_data),
        .frame_enable    (frame_enable),
        .wr_slot         (wr_slot),
        .vram_we         (vram_we),
        .vram_write_addr (vram_write_addr),
        .vram_write_data (vram_write_data),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] pixv(input int x, input int y);
        return {10'(y), 10'(x), 10'(x ^ (y * 3))};
    endfunction

    always @(negedge clk) begin
        if (vram_we) begin
            if (wr_cnt == 0) first_addr = vram_write_addr;
            wr_cnt++;
            last_addr = vram_write_addr;
            alog.push_back(vram_write_addr);
            if (int'(vram_write_addr[9:0]) > max_x)
                max_x = int'(vram_write_addr[9:0]);
            if (vram_write_addr == 19'h0027F) seen_27f = 1;
            if (vram_write_data !== {6'b0,
                    pixv(int'(vram_write_addr[9:0]),
                         int'(vram_write_addr[18:10]))})
                bad_data++;
            if (fd_cnt > 0) wr_after_fd++;
        end
        if (frame_done) fd_cnt++;
    end

    task automatic clr_mon();
        wr_cnt = 0; fd_cnt = 0; wr_after_fd = 0; bad_data = 0;
        max_x = 0; seen_27f = 0; first_addr = '0; last_addr = '0;
        alog.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic px(input bit sof, input bit eol, input int x, input int y);
        pix_valid = 1'b1; pix_sof = sof; pix_eol = eol;
        pix_data = pixv(x, y);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    endtask

    task automatic send_frame(input int w);
        for (int y = 0; y < TV; y++)
            for (int x = 0; x < w; x++)
                px(x == 0 && y == 0, x == w - 1, x, y);
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(2); reset = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (fd_cnt == 0 && n < budget) begin idle(1); n++; end
        total++;
        if (fd_cnt == 0)
            $display("FAIL %s_done: no frame_done within %0d cycles, required a pulse", nm, budget);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_slot = 1'b0; frame_enable = 1'b1;
        idle(3);
        reset = 1'b0;
        total++; if (vram_we !== 1'b0) $display("FAIL rst_we: got %b want 0", vram_we); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL rst_done: got %b want 0", frame_done); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (vram_write_addr !== 19'h0) $display("FAIL rst_addr: got %h want 0", vram_write_addr); else passed++;
        total++; if (vram_write_data !== 36'h0) $display("FAIL rst_data: got %h want 0", vram_write_data); else passed++;
    endtask

    task automatic test_full_frame();
        clr_mon(); wr_slot = 1'b1; frame_enable = 1'b1;
        px(1, 0, 0, 0);
        total++; if (vram_we !== 1'b0) $display("FAIL lat_t1: got we=%b want 0", vram_we); else passed++;
        px(0, 0, 1, 0);
        total++; if (vram_we !== 1'b1 || vram_write_addr !== 19'h0)
            $display("FAIL lat_t2: got we=%b addr=%h want we=1 addr=0", vram_we, vram_write_addr);
        else passed++;
        for (int y = 0; y < TV; y++)
            for (int x = 0; x < TH; x++)
                if (y > 0 || x >= 2) px(0, x == TH - 1, x, y);
        wait_done(50, "full");
        idle(5);
        total++; if (wr_cnt != FULL) $display("FAIL full_cnt: got %0d want %0d", wr_cnt, FULL); else passed++;
        total++; if (first_addr !== 19'h0) $display("FAIL full_first: got %h want 0", first_addr); else passed++;
        total++; if (!seen_27f) $display("FAIL full_27f: got not-seen want seen"); else passed++;
        total++; if (last_addr !== 19'h00E7F) $display("FAIL full_last: got %h want 00e7f", last_addr); else passed++;
        total++; if (fd_cnt != 1) $display("FAIL full_fdcnt: got %0d want 1", fd_cnt); else passed++;
        total++; if (wr_after_fd != 0) $display("FAIL full_order: got %0d writes after done want 0", wr_after_fd); else passed++;
        total++; if (bad_data != 0) $display("FAIL full_data: got %0d bad want 0", bad_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL full_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_long_lines();
        clr_mon(); wr_slot = 1'b1;
        send_frame(700);
        wait_done(50, "long");
        idle(5);
        total++; if (wr_cnt != FULL) $display("FAIL long_cnt: got %0d want %0d", wr_cnt, FULL); else passed++;
        total++; if (max_x != 639) $display("FAIL long_maxx: got %0d want 639", max_x); else passed++;
        total++; if (bad_data != 0) $display("FAIL long_data: got %0d bad want 0", bad_data); else passed++;
        total++; if (fd_cnt != 1) $display("FAIL long_fdcnt: got %0d want 1", fd_cnt); else passed++;
        total++; if (last_addr !== 19'h00E7F) $display("FAIL long_last: got %h want 00e7f", last_addr); else passed++;
    endtask

    task automatic test_overflow();
        int bad;
        do_reset(); clr_mon(); wr_slot = 1'b0;
        for (int i = 0; i < 12; i++) begin
            px(i == 0, 0, i, 0);
            if (i == 7) begin
                total++; if (overflow !== 1'b0) $display("FAIL ovf_8th: got %b want 0", overflow); else passed++;
            end
            if (i == 8) begin
                total++; if (overflow !== 1'b1) $display("FAIL ovf_9th: got %b want 1", overflow); else passed++;
            end
        end
        idle(8);
        total++; if (wr_cnt != 0) $display("FAIL ovf_hold: got %0d writes want 0", wr_cnt); else passed++;
        wr_slot = 1'b1;
        idle(12);
        total++; if (wr_cnt != 8) $display("FAIL ovf_cnt: got %0d want 8", wr_cnt); else passed++;
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (i >= alog.size() || alog[i] !== 19'(i)) bad++;
        total++; if (bad != 0) $display("FAIL ovf_order: got %0d misplaced want 0", bad); else passed++;
        total++; if (bad_data != 0) $display("FAIL ovf_data: got %0d bad want 0", bad_data); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passed++;
    endtask

    task automatic test_frame_disable();
        do_reset(); clr_mon(); wr_slot = 1'b1; frame_enable = 1'b0;
        px(1, 0, 0, 0);
        total++; if (busy !== 1'b0) $display("FAIL dis_busy0: got %b want 0", busy); else passed++;
        for (int y = 0; y < TV; y++)
            for (int x = 0; x < TH; x++)
                if (y > 0 || x > 0) px(0, x == TH - 1, x, y);
        idle(5);
        total++; if (wr_cnt != 0) $display("FAIL dis_cnt: got %0d want 0", wr_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL dis_busy: got %b want 0", busy); else passed++;
        total++; if (fd_cnt != 0) $display("FAIL dis_fd: got %0d want 0", fd_cnt); else passed++;
        frame_enable = 1'b1;
        send_frame(TH);
        wait_done(50, "dis");
        idle(5);
        total++; if (first_addr !== 19'h0) $display("FAIL dis_first: got %h want 0", first_addr); else passed++;
        total++; if (wr_cnt != FULL) $display("FAIL dis_resume: got %0d want %0d", wr_cnt, FULL); else passed++;
    endtask

    task automatic test_sof_restart();
        do_reset(); clr_mon(); wr_slot = 1'b1; frame_enable = 1'b1;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < TH; x++)
                if (y < 2 || x < 100) px(x == 0 && y == 0, x == TH - 1, x, y);
        px(1, 0, 0, 0);
        idle(4);
        total++; if (fd_cnt != 0) $display("FAIL sof_nodone: got %0d want 0", fd_cnt); else passed++;
        total++; if (alog.size() <= 1380 || alog[1380] !== 19'h0)
            $display("FAIL sof_addr0: got %0d writes want entry 1380 at addr 0", alog.size());
        else passed++;
        for (int y = 0; y < TV; y++)
            for (int x = 0; x < TH; x++)
                if (y > 0 || x > 0) px(0, x == TH - 1, x, y);
        wait_done(50, "sof");
        idle(5);
        total++; if (fd_cnt != 1) $display("FAIL sof_fdcnt: got %0d want 1", fd_cnt); else passed++;
        total++; if (wr_cnt != 1380 + FULL) $display("FAIL sof_cnt: got %0d want %0d", wr_cnt, 1380 + FULL); else passed++;
        total++; if (bad_data != 0) $display("FAIL sof_data: got %0d bad want 0", bad_data); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset(); clr_mon(); wr_slot = 1'b0; frame_enable = 1'b1;
        for (int i = 0; i < 5; i++) px(i == 0, 0, i, 0);
        total++; if (busy !== 1'b1) $display("FAIL rmid_pre: got busy=%b want 1", busy); else passed++;
        wr_slot = 1'b1; reset = 1'b1;
        idle(1);
        reset = 1'b0;
        total++; if (vram_we !== 1'b0) $display("FAIL rmid_we: got %b want 0", vram_we); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rmid_ovf: got %b want 0", overflow); else passed++;
        idle(5);
        total++; if (wr_cnt != 0) $display("FAIL rmid_flush: got %0d writes want 0", wr_cnt); else passed++;
        send_frame(TH);
        wait_done(50, "rmid");
        idle(5);
        total++; if (first_addr !== 19'h0) $display("FAIL rmid_first: got %h want 0", first_addr); else passed++;
        total++; if (wr_cnt != FULL) $display("FAIL rmid_cnt: got %0d want %0d", wr_cnt, FULL); else passed++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_long_lines();
        test_overflow();
        test_frame_disable();
        test_sof_restart();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
